// File: rtl/dec_ser_pkg.sv
// Shared sizing helpers and state type for the multi-channel decimator serializer.
package dec_ser_pkg;

  localparam int unsigned DATA_W_DEF = 22;
  localparam int unsigned N_CH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } sched_state_t;

  function automatic int unsigned id_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int unsigned frame_w(input int unsigned n_ch, input int unsigned data_w);
    return id_w(n_ch) + data_w;
  endfunction

endpackage

// File: rtl/dec_ser_channel_scheduler_if.sv
// Channel-side strobes/words and serial-link outputs of the channel scheduler.
interface dec_ser_channel_scheduler_if
  import dec_ser_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned ID_W = id_w(N_CH);

  logic                     en_i;
  logic [N_CH-1:0]          valid_strobe_i;
  logic [N_CH*DATA_W-1:0]   data_i;
  logic                     overrun_clr_i;
  logic                     data_o;
  logic                     frame_sync_o;
  logic [ID_W-1:0]          ch_id_o;
  logic                     busy_o;
  logic [N_CH-1:0]          overrun_o;

  modport master (
    output en_i, valid_strobe_i, data_i, overrun_clr_i,
    input  data_o, frame_sync_o, ch_id_o, busy_o, overrun_o
  );

  modport slave (
    input  en_i, valid_strobe_i, data_i, overrun_clr_i,
    output data_o, frame_sync_o, ch_id_o, busy_o, overrun_o
  );
endinterface

// File: rtl/dec_strobe_capture.sv
// Per-channel strobe synchronizer with rising-edge capture, pending and sticky overrun flags.
module dec_strobe_capture #(
  parameter int unsigned DATA_W = 22
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  input  logic              clr_pending,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] hold,
  output logic              pending,
  output logic              overrun
);

  logic [2:0] sync_q;
  logic       rise_c;

  assign rise_c = sync_q[1] & ~sync_q[2];

  // A capture always wins over a grant clear, so a word arriving on its own grant cycle stays pending.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q  <= '0;
      hold    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], strobe};
      if (rise_c) begin
        hold <= data;
      end
      if (rise_c) begin
        pending <= 1'b1;
      end else if (clr_pending) begin
        pending <= 1'b0;
      end
      if (rise_c && pending && !clr_pending) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dec_ser_channel_scheduler.sv
// Round-robin scheduler sharing one serial link among N_CH decimator channels;
// frames are {channel id, data} MSB-first with frame sync and a fixed inter-frame gap.
module dec_ser_channel_scheduler
  import dec_ser_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned GAP_CYC = 2
) (
  input logic                    clk,
  input logic                    rst_b,
  dec_ser_channel_scheduler_if.slave bus
);

  localparam int unsigned ID_W     = id_w(N_CH);
  localparam int unsigned FRAME_W  = frame_w(N_CH, DATA_W);
  localparam int unsigned CNT_W    = $clog2(FRAME_W);
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  logic [DATA_W-1:0]  hold_c [N_CH];
  logic [N_CH-1:0]    pending_c;
  logic [N_CH-1:0]    overrun_c;
  logic [N_CH-1:0]    clr_vec_c;

  sched_state_t       state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               fs_q, fs_d;
  logic               busy_q;
  logic [ID_W-1:0]    ch_id_q, ch_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               gnt_found_c;
  logic [ID_W-1:0]    gnt_c;
  int unsigned        idx_c;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    dec_strobe_capture #(.DATA_W(DATA_W)) u_cap (
      .clk         (clk),
      .rst_b       (rst_b),
      .strobe      (bus.valid_strobe_i[k]),
      .data        (bus.data_i[k*DATA_W +: DATA_W]),
      .clr_pending (clr_vec_c[k]),
      .overrun_clr (bus.overrun_clr_i),
      .hold        (hold_c[k]),
      .pending     (pending_c[k]),
      .overrun     (overrun_c[k])
    );
  end

  // Round-robin search starting at ptr_q, wrapping modulo N_CH.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_c       = '0;
    idx_c       = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx_c = 32'(ptr_q) + i;
      if (idx_c >= N_CH) begin
        idx_c = idx_c - N_CH;
      end
      if (!gnt_found_c && pending_c[ID_W'(idx_c)]) begin
        gnt_found_c = 1'b1;
        gnt_c       = ID_W'(idx_c);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    fs_d      = fs_q;
    ch_id_d   = ch_id_q;
    ptr_d     = ptr_q;
    clr_vec_c = '0;
    case (state_q)
      IDLE: begin
        if (bus.en_i && gnt_found_c) begin
          shreg_d          = {gnt_c, hold_c[gnt_c]};
          clr_vec_c[gnt_c] = 1'b1;
          ch_id_d          = gnt_c;
          bit_cnt_d        = CNT_W'(FRAME_W - 1);
          fs_d             = 1'b1;
          ptr_d            = (gnt_c == ID_W'(N_CH - 1)) ? '0 : gnt_c + ID_W'(1);
          state_d          = SHIFT;
        end
      end
      SHIFT: begin
        // The final shift empties shreg, so data_o returns to 0 with frame sync.
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          fs_d      = 1'b0;
          gap_cnt_d = GAP_W'(GAP_LOAD);
          state_d   = (GAP_CYC == 0) ? IDLE : GAP;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      ch_id_q   <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      fs_q      <= fs_d;
      busy_q    <= (state_d != IDLE);
      ch_id_q   <= ch_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.data_o       = shreg_q[FRAME_W-1];
  assign bus.frame_sync_o = fs_q;
  assign bus.ch_id_o      = ch_id_q;
  assign bus.busy_o       = busy_q;
  assign bus.overrun_o    = overrun_c;

endmodule

// File: tb/tb_dec_ser_channel_scheduler.sv
// Directed bench for dec_ser_channel_scheduler: table of single-channel frames plus multi-cycle corner sequences.
module tb_dec_ser_channel_scheduler;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned DATA_W  = 22;
  localparam int unsigned GAP_CYC = 2;

  typedef struct {
    int          ch;
    logic [21:0] data;
    logic [31:0] exp_frame;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dec_ser_channel_scheduler_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  dec_ser_channel_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int ch, input logic [21:0] d);
    bus.data_i[ch*DATA_W +: DATA_W] = d;
    bus.valid_strobe_i[ch] = 1'b1;
    repeat (3) @(negedge clk);
    bus.valid_strobe_i[ch] = 1'b0;
  endtask

  // Collects one frame; returns at the first negedge with frame_sync_o low.
  task automatic receive(input int drop_at, output logic [31:0] frame, output logic [31:0] id,
                         output int len);
    int t;
    t     = 0;
    frame = '0;
    id    = '0;
    len   = 0;
    while (!bus.frame_sync_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.frame_sync_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: no frame_sync_o within %0d cycles", t);
      return;
    end
    check("busy_at_frame_start", 32'(bus.busy_o), 32'd1);
    id = 32'(bus.ch_id_o);
    while (bus.frame_sync_o && len < 64) begin
      frame = {frame[30:0], bus.data_o};
      len++;
      if (len == drop_at) bus.en_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!bus.frame_sync_o && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.frame_sync_o || bus.data_o) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    logic [31:0] frame;
    logic [31:0] id;
    int          len;
    int          low;
    int          t;

    vecs[0] = '{ch: 0, data: 22'h3FFFFF, exp_frame: 32'h003FFFFF};
    vecs[1] = '{ch: 1, data: 22'h000001, exp_frame: 32'h00400001};
    vecs[2] = '{ch: 2, data: 22'h2A5A5A, exp_frame: 32'h00AA5A5A};
    vecs[3] = '{ch: 3, data: 22'h155555, exp_frame: 32'h00D55555};
    vecs[4] = '{ch: 3, data: 22'h000000, exp_frame: 32'h00C00000};

    bus.en_i           = 1'b0;
    bus.valid_strobe_i = '0;
    bus.data_i         = '0;
    bus.overrun_clr_i  = 1'b0;
    rst_b              = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_data_o", 32'(bus.data_o), 32'd0);
    check("rst_frame_sync_o", 32'(bus.frame_sync_o), 32'd0);
    check("rst_ch_id_o", 32'(bus.ch_id_o), 32'd0);
    check("rst_busy_o", 32'(bus.busy_o), 32'd0);
    check("rst_overrun_o", 32'(bus.overrun_o), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Single word on ch2 with latency check
    bus.en_i = 1'b1;
    bus.data_i[2*DATA_W +: DATA_W] = 22'h2A5A5A;
    bus.valid_strobe_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    bus.valid_strobe_i[2] = 1'b0;
    check("latency_edge3_fs_low", 32'(bus.frame_sync_o), 32'd0);
    @(negedge clk);
    check("latency_edge4_fs_high", 32'(bus.frame_sync_o), 32'd1);
    receive(-1, frame, id, len);
    check("single_frame", frame, 32'h00AA5A5A);
    check("single_id", id, 32'd2);
    check("single_len", 32'(len), 32'd24);
    check("single_overrun", 32'(bus.overrun_o), 32'd0);
    check("gap_busy", 32'(bus.busy_o), 32'd1);
    check("gap_data_o", 32'(bus.data_o), 32'd0);
    check("last_ch_id_held", 32'(bus.ch_id_o), 32'd2);

    // Table of isolated single-channel frames
    for (int i = 0; i < 5; i++) begin
      pulse(vecs[i].ch, vecs[i].data);
      receive(-1, frame, id, len);
      check($sformatf("vec%0d_frame", i), frame, vecs[i].exp_frame);
      check($sformatf("vec%0d_id", i), id, 32'(vecs[i].ch));
      check($sformatf("vec%0d_len", i), 32'(len), 32'd24);
    end

    // Round-robin from ptr 0 with all four strobes together
    do_reset();
    bus.data_i = {22'h000004, 22'h000003, 22'h000002, 22'h000001};
    bus.valid_strobe_i = 4'hF;
    repeat (3) @(negedge clk);
    bus.valid_strobe_i = '0;
    for (int c = 0; c < 4; c++) begin
      receive(-1, frame, id, len);
      check($sformatf("rr%0d_frame", c), frame, (32'(c) << 22) | 32'(c + 1));
      check($sformatf("rr%0d_id", c), id, 32'(c));
      if (c < 3) begin
        count_low(low);
        check($sformatf("rr%0d_gap", c), 32'(low), 32'd3);
      end
    end
    // ptr wrapped to 0: ch0 must win over ch2
    bus.data_i[0 +: DATA_W] = 22'h00000A;
    bus.data_i[2*DATA_W +: DATA_W] = 22'h00000B;
    bus.valid_strobe_i = 4'b0101;
    repeat (3) @(negedge clk);
    bus.valid_strobe_i = '0;
    receive(-1, frame, id, len);
    check("ptr_wrap_first_id", id, 32'd0);
    receive(-1, frame, id, len);
    check("ptr_wrap_second_frame", frame, 32'h0080000B);

    // Overrun while disabled
    bus.en_i = 1'b0;
    repeat (4) @(negedge clk);
    pulse(1, 22'h111111);
    repeat (4) @(negedge clk);
    pulse(1, 22'h222222);
    repeat (2) @(negedge clk);
    check("ovr_flag_set", 32'(bus.overrun_o), 32'h2);
    check("ovr_no_frame_disabled", 32'(bus.frame_sync_o), 32'd0);
    bus.en_i = 1'b1;
    receive(-1, frame, id, len);
    check("ovr_frame", frame, 32'h00622222);
    check("ovr_id", id, 32'd1);
    expect_quiet("ovr_single_frame", 40);
    check("ovr_flag_sticky", 32'(bus.overrun_o), 32'h2);
    bus.overrun_clr_i = 1'b1;
    @(negedge clk);
    bus.overrun_clr_i = 1'b0;
    check("ovr_flag_cleared", 32'(bus.overrun_o), 32'd0);

    // Capture coincident with grant on ch0
    bus.en_i = 1'b0;
    pulse(0, 22'h0AAAAA);
    repeat (3) @(negedge clk);
    bus.data_i[0 +: DATA_W] = 22'h155555;
    bus.valid_strobe_i[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus.en_i = 1'b1;
    @(negedge clk);
    bus.valid_strobe_i[0] = 1'b0;
    check("cg_fs_at_grant", 32'(bus.frame_sync_o), 32'd1);
    receive(-1, frame, id, len);
    check("cg_old_frame", frame, 32'h000AAAAA);
    count_low(low);
    check("cg_gap", 32'(low), 32'd3);
    receive(-1, frame, id, len);
    check("cg_new_frame", frame, 32'h00155555);
    check("cg_no_overrun", 32'(bus.overrun_o), 32'd0);

    // Enable dropped mid-frame; ch3 waits for enable
    bus.en_i = 1'b0;
    pulse(1, 22'h0F0F0F);
    pulse(3, 22'h30C30C);
    repeat (2) @(negedge clk);
    bus.en_i = 1'b1;
    receive(5, frame, id, len);
    check("en_drop_frame", frame, 32'h004F0F0F);
    check("en_drop_len", 32'(len), 32'd24);
    expect_quiet("en_low_no_grant", 30);
    check("en_low_idle", 32'(bus.busy_o), 32'd0);
    bus.en_i = 1'b1;
    receive(-1, frame, id, len);
    check("en_resume_frame", frame, 32'h00F0C30C);
    check("en_resume_id", id, 32'd3);

    // Asynchronous reset at bit 10
    pulse(3, 22'h3FFFFF);
    t = 0;
    while (!bus.frame_sync_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check("mid_rst_pre_data", 32'(bus.data_o), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("mid_rst_data_o", 32'(bus.data_o), 32'd0);
    check("mid_rst_frame_sync_o", 32'(bus.frame_sync_o), 32'd0);
    check("mid_rst_busy_o", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    expect_quiet("post_rst_no_frame", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
